e_mdu: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded E-stage operands (post-forward rs/rt values) plus a decoded MD opcode from the E-stage controller.
- Holds architectural HI/LO and executes mult/multu/div/divu over a fixed multi-cycle latency.
- Exposes busy so the hazard controller stalls D-stage MD instructions (mult/div/mthi/mtlo/mfhi/mflo) while start|busy.

---
 rtl/e_mdu.sv | 258 +++++++++++++++++++++++++
 tb/tb_e_mdu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// ============================================================================
// e_mdu -- E-stage multiply/divide unit for the 5-stage MIPS pipeline
//
// Holds the architectural HI/LO pair and executes mult/multu/div/divu with a
// fixed multi-cycle latency. mthi/mtlo write HI/LO in a single edge.
// The hazard unit stalls D-stage MD instructions while (start | busy).
//
// Parameters:
//   MULT_CYCLES : cycles busy stays high for mult/multu (>= 1)
//   DIV_CYCLES  : cycles busy stays high for div/divu   (>= 1)
//
// Ports:
//   clk     in   1   pipeline clock, rising edge
//   reset   in   1   asynchronous, active-low reset
//   flush   in   1   abort in-flight op / suppress start (MDU_FLUSH_EN only)
//   start   in   1   E-stage instruction is an MD instruction this cycle
//   mdu_op  in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                    7 reserved (treated as NONE)
//   a       in   32  forwarded rs value
//   b       in   32  forwarded rt value
//   busy    out  1   registered; high while a mult/div is in flight
//   hi      out  32  architectural HI (registered)
//   lo      out  32  architectural LO (registered)
//
// Optional feature macro: MDU_FLUSH_EN
//   Defined   -> adds the flush input; flush aborts a running op (result
//                dropped, HI/LO unchanged) and suppresses a start in IDLE.
//   Undefined -> no flush port; operations always run to completion.
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Conditional two's-complement negation.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;

    logic             w_flush;

`ifdef MDU_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Result datapath, computed from the latched operands. It only becomes
    // architectural on the completing edge.
    // ------------------------------------------------------------------------
    logic        w_is_sdiv;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Sign-extend to 64 bits so the low 64 bits of the product are the exact
    // signed result.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide is done on magnitudes so the INT_MIN / -1 case wraps to
    // 0x80000000 without relying on signed-division overflow semantics.
    assign w_is_sdiv  = (r_op == OP_DIV);
    assign w_dvd_mag  = w_is_sdiv ? abs32(r_a) : r_a;
    assign w_dvs_mag  = w_is_sdiv ? abs32(r_b) : r_b;
    // Divisor forced non-zero so the divider never sees /0; the result is
    // discarded in that case anyway.
    assign w_dvs_safe = (w_dvs_mag == 32'd0) ? 32'd1 : w_dvs_mag;
    assign w_quo_mag  = w_dvd_mag / w_dvs_safe;
    assign w_rem_mag  = w_dvd_mag % w_dvs_safe;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_quo      = neg_if(w_is_sdiv & (r_a[31] ^ r_b[31]), w_quo_mag);
    assign w_rem      = neg_if(w_is_sdiv & r_a[31], w_rem_mag);

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    // Select the completion value for HI/LO and whether it may be written.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_we = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO untouched.
                if (r_b != 32'd0) begin
                    w_res_hi = w_rem;
                    w_res_lo = w_quo;
                    w_res_we = 1'b1;
                end else begin
                    w_res_hi = r_hi;
                    w_res_lo = r_lo;
                    w_res_we = 1'b0;
                end
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
                w_res_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM: IDLE accepts new ops, RUN counts down the fixed latency.
    // Starts arriving while RUN are ignored so the in-flight op is preserved.
    // ------------------------------------------------------------------------
    // FSM, operand latches, cycle counter and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= CNT_ZERO;
            r_op    <= OP_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_flush) begin
                        // Flush suppresses any coincident start, mthi/mtlo too.
                        r_busy <= 1'b0;
                    end else if (start) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                r_op    <= mdu_op;
                                r_a     <= a;
                                r_b     <= b;
                                r_count <= MULT_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_op    <= mdu_op;
                                r_a     <= a;
                                r_b     <= b;
                                r_count <= DIV_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: r_busy <= 1'b0;
                        endcase
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_flush) begin
                        // Abort has priority over completion: result dropped.
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_count == CNT_ONE) begin
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (w_res_we) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                default: begin
                    r_count <= CNT_ZERO;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// ============================================================================
// tb_e_mdu -- directed self-checking bench for e_mdu (default parameters:
// MULT_CYCLES=5, DIV_CYCLES=10). Expected values are hand-computed constants.
// ============================================================================
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif

    int n_cmp;
    int n_err;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MDU_FLUSH_EN
        .flush  (flush),
`endif
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an MD instruction for exactly one edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start  = 1'b1;
        mdu_op = op;
        a      = va;
        b      = vb;
        tick();
        start  = 1'b0;
        mdu_op = 3'd0;
    endtask

    // Count cycles with busy high, starting from 'already' observed cycles.
    task automatic count_busy(input int already, output int total);
        total = already;
        while (busy === 1'b1 && total < 50) begin
            tick();
            if (busy === 1'b1) total++;
        end
    endtask

    // Issue a mult/div and check latency and final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] va, input logic [31:0] vb,
                          input int ncyc, input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        issue(op, va, vb);
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        count_busy(1, c);
        chk({tag, "_cycles"}, c, ncyc);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        int c;
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
`ifdef MDU_FLUSH_EN
        flush  = 1'b0;
`endif

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();

        // MTHI / MTLO
        issue(3'd5, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        issue(3'd6, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);

        // NONE and reserved opcode have no effect
        issue(3'd0, 32'h11111111, 32'd0);
        issue(3'd7, 32'h22222222, 32'd0);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, 32'h12345678);
        chk("nop_lo", lo, 32'h9ABCDEF0);

        // Multiplies
        run_op("mult",  3'd1, 32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE);

        // Divides
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003);

        // Divide by zero leaves HI/LO unchanged
        issue(3'd5, 32'hAAAA0000, 32'd0);
        issue(3'd6, 32'h0000BBBB, 32'd0);
        run_op("div0",  3'd3, 32'h00000005, 32'h00000000, 10, 32'hAAAA0000, 32'h0000BBBB);

        // INT_MIN / -1
        run_op("divmin", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

        // Start while busy is ignored
        issue(3'd1, 32'd3, 32'd4);
        chk("ign_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("ign_busy2", {31'd0, busy}, 32'd1);
        issue(3'd4, 32'd100, 32'd7);
        count_busy(3, c);
        chk("ign_cycles", c, 32'd5);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd12);
        tick();
        tick();
        chk("ign_no_retrigger", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation
        issue(3'd5, 32'h00000055, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        chk("arst_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        chk("arst_stay_idle", {31'd0, busy}, 32'd0);
        run_op("post_rst", 3'd2, 32'd6, 32'd7, 5, 32'd0, 32'd42);

`ifdef MDU_FLUSH_EN
        // Flush aborts a running op on busy cycle 3
        issue(3'd5, 32'h0000CAFE, 32'd0);
        issue(3'd1, 32'd9, 32'd9);
        tick();
        tick();
        chk("fl_busy_c3", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_hi", hi, 32'h0000CAFE);
        chk("fl_lo", lo, 32'd42);
        // Flush in IDLE suppresses mthi
        flush = 1'b1;
        issue(3'd5, 32'h0BADF00D, 32'd0);
        flush = 1'b0;
        chk("fl_idle_busy", {31'd0, busy}, 32'd0);
        chk("fl_idle_hi", hi, 32'h0000CAFE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
